// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_bank block.
//   cnt_width() - width of an occupancy counter able to hold 0..depth
//   is_pow2()   - parameter legality helper
//   MIN_DEPTH / MAX_CH - legal parameter limits
package fifo_pkg;

    localparam int MIN_DEPTH = 4;
    localparam int MAX_CH    = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// sync_fifo_ch: one synchronous FIFO channel.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   i_wdata, i_wena     - write word and write enable
//   i_rena              - read enable (pop)
//   i_clr_err           - clears the sticky overflow/underflow flags
//   o_rdata             - head word (registered on pop, or fall-through when FWFT=1)
//   o_full, o_almost_full, o_empty, o_almost_empty - status decoded from count
//   o_count             - occupancy 0..DEPTH
//   o_overflow, o_underflow - sticky error flags
module sync_fifo_ch
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    input  logic                        i_wena,
    input  logic                        i_rena,
    input  logic                        i_clr_err,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic                        o_full,
    output logic                        o_almost_full,
    output logic                        o_empty,
    output logic                        o_almost_empty,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] L_AE    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_wr_drop;
    logic w_rd_drop;

    // Status always comes from the occupancy counter; with wrapping pointers
    // wptr==rptr is ambiguous between full and empty.
    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a pop frees the slot in the same cycle.
    assign w_rd_ok   = i_rena & ~w_empty;
    assign w_wr_ok   = i_wena & (~w_full | w_rd_ok);
    assign w_wr_drop = i_wena & ~w_wr_ok;
    assign w_rd_drop = i_rena & ~w_rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh error in the clearing cycle keeps the flag set.
            r_overflow  <= (r_overflow  & ~i_clr_err) | w_wr_drop;
            r_underflow <= (r_underflow & ~i_clr_err) | w_rd_drop;
        end
    end

    // Storage is not reset; stale words are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rdata = r_mem[r_rptr];
        end else begin : g_reg_rd
            logic [DATA_WIDTH-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_rd_ok) begin
                    r_rdata <= r_mem[r_rptr];
                end
            end
            assign o_rdata = r_rdata;
        end
    endgenerate

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= L_AF);
    assign o_almost_empty = (r_count <= L_AE);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: rtl/fifo_bank.sv
// fifo_bank: NUM_CH independent synchronous FIFOs sharing one clock.
// Ports (channel c occupies slice c of every vector):
//   clk, rst          - clock, synchronous active-high reset
//   wdata, wena       - write data [c*DATA_WIDTH +: DATA_WIDTH], write enables
//   rena              - read enables
//   clr_err           - per-channel clear of overflow/underflow
//   rdata             - read data, packed like wdata
//   full, almost_full, empty, almost_empty - per-channel status
//   count             - per-channel occupancy, cnt_width(DEPTH) bits each
//   overflow, underflow - per-channel sticky error flags
module fifo_bank
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         wdata,
    input  logic [NUM_CH-1:0]                    wena,
    input  logic [NUM_CH-1:0]                    rena,
    input  logic [NUM_CH-1:0]                    clr_err,
    output logic [NUM_CH*DATA_WIDTH-1:0]         rdata,
    output logic [NUM_CH-1:0]                    full,
    output logic [NUM_CH-1:0]                    almost_full,
    output logic [NUM_CH-1:0]                    empty,
    output logic [NUM_CH-1:0]                    almost_empty,
    output logic [NUM_CH*cnt_width(DEPTH)-1:0]   count,
    output logic [NUM_CH-1:0]                    overflow,
    output logic [NUM_CH-1:0]                    underflow
);

    localparam int CW = cnt_width(DEPTH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH) begin : g_bad_depth
            $error("fifo_bank: DEPTH must be a power of two and at least %0d", MIN_DEPTH);
        end
        if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
            $error("fifo_bank: NUM_CH must be in 1..%0d", MAX_CH);
        end
        if (AE_THRESH >= AF_THRESH) begin : g_bad_ae
            $error("fifo_bank: AE_THRESH must be below AF_THRESH");
        end
        if (AF_THRESH > DEPTH) begin : g_bad_af
            $error("fifo_bank: AF_THRESH must not exceed DEPTH");
        end
    endgenerate

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            sync_fifo_ch #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .AF_THRESH  (AF_THRESH),
                .AE_THRESH  (AE_THRESH),
                .FWFT       (FWFT)
            ) u_ch (
                .clk            (clk),
                .rst            (rst),
                .i_wdata        (wdata[c*DATA_WIDTH +: DATA_WIDTH]),
                .i_wena         (wena[c]),
                .i_rena         (rena[c]),
                .i_clr_err      (clr_err[c]),
                .o_rdata        (rdata[c*DATA_WIDTH +: DATA_WIDTH]),
                .o_full         (full[c]),
                .o_almost_full  (almost_full[c]),
                .o_empty        (empty[c]),
                .o_almost_empty (almost_empty[c]),
                .o_count        (count[c*CW +: CW]),
                .o_overflow     (overflow[c]),
                .o_underflow    (underflow[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fifo_bank.sv
module tb_fifo_bank;
    import fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NCH   = 4;
    localparam int CW    = cnt_width(DEPTH);
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NCH*DW-1:0]   wdata;
    logic [NCH-1:0]      wena, rena, clr_err;
    logic [NCH*DW-1:0]   rdata;
    logic [NCH-1:0]      full, almost_full, empty, almost_empty, overflow, underflow;
    logic [NCH*CW-1:0]   count;

    logic [NCH*DW-1:0]   f_wdata;
    logic [NCH-1:0]      f_wena, f_rena, f_clr;
    logic [NCH*DW-1:0]   f_rdata;
    logic [NCH-1:0]      f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
    logic [NCH*CW-1:0]   f_count;

    fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) u_dut (
        .clk(clk), .rst(rst), .wdata(wdata), .wena(wena), .rena(rena), .clr_err(clr_err),
        .rdata(rdata), .full(full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wdata(f_wdata), .wena(f_wena), .rena(f_rena), .clr_err(f_clr),
        .rdata(f_rdata), .full(f_full), .almost_full(f_af), .empty(f_empty),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    // Reference model: one queue per channel plus sticky flags and last-read word.
    logic [DW-1:0] mq [NCH][$];
    logic [DW-1:0] m_rd  [NCH];
    logic          m_ovf [NCH];
    logic          m_unf [NCH];

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [NCH-1:0] wena;
        logic [NCH-1:0] rena;
        logic [NCH-1:0] clr;
        int             cnt;
        logic           full, empty, ae, af, ovf, unf;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %h expected %h at %0t", name, ch, act, exp, $time);
        end
    endtask

    task automatic tick();
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                mq[c].delete();
                m_rd[c]  = '0;
                m_ovf[c] = 1'b0;
                m_unf[c] = 1'b0;
            end else begin
                int  sz;
                bit  rd_ok, wr_ok;
                sz    = mq[c].size();
                rd_ok = rena[c] && (sz > 0);
                wr_ok = wena[c] && ((sz < DEPTH) || rd_ok);
                if (rd_ok) m_rd[c] = mq[c].pop_front();
                if (wr_ok) mq[c].push_back(wdata[c*DW +: DW]);
                m_ovf[c] = (m_ovf[c] && !clr_err[c]) || (wena[c] && !wr_ok);
                m_unf[c] = (m_unf[c] && !clr_err[c]) || (rena[c] && !rd_ok);
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            int sz;
            sz = mq[c].size();
            chk("count", c, 32'(count[c*CW +: CW]), 32'(sz));
            chk("full", c, 32'(full[c]), 32'(sz == DEPTH));
            chk("empty", c, 32'(empty[c]), 32'(sz == 0));
            chk("almost_full", c, 32'(almost_full[c]), 32'(sz >= AF));
            chk("almost_empty", c, 32'(almost_empty[c]), 32'(sz <= AE));
            chk("overflow", c, 32'(overflow[c]), 32'(m_ovf[c]));
            chk("underflow", c, 32'(underflow[c]), 32'(m_unf[c]));
            chk("rdata", c, rdata[c*DW +: DW], m_rd[c]);
        end
        rst     = 1'b0;
        wena    = '0;
        rena    = '0;
        clr_err = '0;
        f_wena  = '0;
        f_rena  = '0;
    endtask

    initial begin
        //                wena  rena  clr   cnt full empty ae af ovf unf
        tbl[0] = '{4'h0, 4'h4, 4'h0, 0, 0, 1, 1, 0, 0, 1};
        tbl[1] = '{4'h0, 4'h0, 4'h4, 0, 0, 1, 1, 0, 0, 0};
        tbl[2] = '{4'h4, 4'h4, 4'h0, 1, 0, 0, 1, 0, 0, 1};
        tbl[3] = '{4'h4, 4'h0, 4'h4, 2, 0, 0, 1, 0, 0, 0};
        tbl[4] = '{4'h4, 4'h0, 4'h0, 3, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{4'h0, 4'h4, 4'h0, 2, 0, 0, 1, 0, 0, 0};
        tbl[6] = '{4'h0, 4'h4, 4'h0, 1, 0, 0, 1, 0, 0, 0};
        tbl[7] = '{4'h0, 4'h4, 4'h0, 0, 0, 1, 1, 0, 0, 0};
        tbl[8] = '{4'h0, 4'h4, 4'h4, 0, 0, 1, 1, 0, 0, 1};
        tbl[9] = '{4'h0, 4'h0, 4'h4, 0, 0, 1, 1, 0, 0, 0};

        rst = 1'b1; wena = '0; rena = '0; clr_err = '0; wdata = '0;
        f_wena = '0; f_rena = '0; f_clr = '0; f_wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            m_rd[c] = '0; m_ovf[c] = 1'b0; m_unf[c] = 1'b0;
        end
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        chk("reset_empty", 0, 32'(empty), 32'hF);
        chk("reset_ae", 0, 32'(almost_empty), 32'hF);
        chk("reset_rdata", 0, rdata[31:0], 32'h0);

        // Table-driven single-cycle vectors on channel 2 (underflow, clear, error-wins).
        for (int i = 0; i < 10; i++) begin
            wena    = tbl[i].wena;
            rena    = tbl[i].rena;
            clr_err = tbl[i].clr;
            wdata[2*DW +: DW] = 32'h2000_0000 + 32'(i);
            tick();
            chk("tbl_cnt", 2, 32'(count[2*CW +: CW]), 32'(tbl[i].cnt));
            chk("tbl_full", 2, 32'(full[2]), 32'(tbl[i].full));
            chk("tbl_empty", 2, 32'(empty[2]), 32'(tbl[i].empty));
            chk("tbl_ae", 2, 32'(almost_empty[2]), 32'(tbl[i].ae));
            chk("tbl_af", 2, 32'(almost_full[2]), 32'(tbl[i].af));
            chk("tbl_ovf", 2, 32'(overflow[2]), 32'(tbl[i].ovf));
            chk("tbl_unf", 2, 32'(underflow[2]), 32'(tbl[i].unf));
        end
        chk("tbl_rdata_hold", 2, rdata[2*DW +: DW], 32'h2000_0004);

        // Fill ch0 with 0x0..0xF.
        for (int i = 0; i < DEPTH; i++) begin
            wena[0] = 1'b1; wdata[31:0] = 32'(i);
            tick();
            chk("fill_af", 0, 32'(almost_full[0]), 32'(i + 1 >= 14));
        end
        chk("fill_full", 0, 32'(full[0]), 32'h1);
        chk("fill_others_empty", 0, 32'(empty[3:1]), 32'h7);

        // Extra write into full ch0 is dropped and flagged.
        wena[0] = 1'b1; wdata[31:0] = 32'h0000_DEAD;
        tick();
        chk("ovf_set", 0, 32'(overflow[0]), 32'h1);
        chk("ovf_count", 0, 32'(count[0 +: CW]), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rena[0] = 1'b1;
            tick();
            chk("drain_order", 0, rdata[31:0], 32'(i));
        end
        clr_err[0] = 1'b1;
        tick();
        chk("ovf_clear", 0, 32'(overflow[0]), 32'h0);

        // Full ch1 under simultaneous push/pop across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            wena[1] = 1'b1; wdata[DW +: DW] = 32'h100 + 32'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            wena[1] = 1'b1; rena[1] = 1'b1; wdata[DW +: DW] = 32'h200 + 32'(i);
            tick();
            chk("wrap_count", 1, 32'(count[CW +: CW]), 32'd16);
            chk("wrap_no_ovf", 1, 32'(overflow[1]), 32'h0);
            chk("wrap_order", 1, rdata[DW +: DW], (i < 16) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 16));
        end
        for (int i = 0; i < DEPTH; i++) begin
            rena[1] = 1'b1;
            tick();
        end

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 7; i++) begin
            wena[0] = 1'b1; wdata[31:0] = 32'h300 + 32'(i);
            tick();
        end
        rst = 1'b1; wena[0] = 1'b1; rena[0] = 1'b1; wdata[31:0] = 32'h0BAD;
        tick();
        chk("rst_count", 0, 32'(count[0 +: CW]), 32'd0);
        chk("rst_empty", 0, 32'(empty[0]), 32'h1);
        wena[0] = 1'b1; wdata[31:0] = 32'h777;
        tick();
        rena[0] = 1'b1;
        tick();
        chk("rst_new_word", 0, rdata[31:0], 32'h777);

        // First-word-fall-through instance.
        f_wena[3] = 1'b1; f_wdata[3*DW +: DW] = 32'hA5;
        tick();
        chk("fwft_head", 3, f_rdata[3*DW +: DW], 32'hA5);
        chk("fwft_nonempty", 3, 32'(f_empty[3]), 32'h0);
        f_wena[3] = 1'b1; f_wdata[3*DW +: DW] = 32'h5A;
        tick();
        chk("fwft_head_hold", 3, f_rdata[3*DW +: DW], 32'hA5);
        f_rena[3] = 1'b1;
        tick();
        chk("fwft_next", 3, f_rdata[3*DW +: DW], 32'h5A);
        chk("fwft_count", 3, 32'(f_count[3*CW +: CW]), 32'd1);
        f_rena[3] = 1'b1;
        tick();
        chk("fwft_empty", 3, 32'(f_empty[3]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
